// File: rtl/ripple_ctrl_pkg.sv
// Shared types and default constants for the ripple counter measurement controller.
package ripple_ctrl_pkg;

    typedef enum logic [2:0] {
        RC_IDLE   = 3'd0,
        RC_CLEAR  = 3'd1,
        RC_COUNT  = 3'd2,
        RC_SETTLE = 3'd3,
        RC_DONE   = 3'd4
    } rc_state_t;

    localparam int unsigned RC_WIDTH      = 4;
    localparam int unsigned RC_CLR_CYC    = 2;
    localparam int unsigned RC_SETTLE_MAX = 8;

    // Synchronizer depth on the asynchronous counter output.
    localparam int unsigned RC_SYNC_LAT   = 2;

endpackage

// File: rtl/cnt_settle_chk.sv
// Brings the asynchronous ripple count into the clk domain and flags stability
// and MSB wrap events on the synchronized value.
module cnt_settle_chk
    import ripple_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = RC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] cnt_q,
    output logic [WIDTH-1:0] smp,
    output logic             eq_c,
    output logic             msb_fall_c
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] prev;

    // While the counter is being cleared its true value is zero, so flush the
    // pipeline to zero; otherwise stale pre-clear bits would fake a wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sync1 <= '0;
            smp   <= '0;
            prev  <= '0;
        end else begin
            sync1 <= cnt_q;
            smp   <= sync1;
            prev  <= smp;
        end
    end

    assign eq_c       = (smp == prev);
    assign msb_fall_c = prev[WIDTH-1] & ~smp[WIDTH-1];

endmodule

// File: rtl/ripple_cnt_ctrl.sv
// Measurement-window controller: clears and gates a ripple counter, waits for
// the count to settle, and returns it over a valid/ready handshake.
module ripple_cnt_ctrl
    import ripple_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = RC_WIDTH,
    parameter int unsigned WIN_W      = 8,
    parameter int unsigned CLR_CYC    = RC_CLR_CYC,
    parameter int unsigned SETTLE_MAX = RC_SETTLE_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIN_W-1:0] win_len,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clr,
    output logic             cnt_gate,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             err
);

    localparam int unsigned CC_W      = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int unsigned SC_W      = $clog2(SETTLE_MAX + 2);
    // First SETTLE cycle whose sample pair was taken entirely after the gate fell.
    localparam int unsigned FIRST_CMP = RC_SYNC_LAT + 1;
    // SETTLE cycle holding the SETTLE_MAX-th synchronized sample.
    localparam int unsigned LAST_SMP  = SETTLE_MAX + 1;

    rc_state_t         state;
    rc_state_t         state_nx;

    logic [WIN_W-1:0]  timer;
    logic [WIN_W-1:0]  timer_d;
    logic [CC_W-1:0]   clr_cnt;
    logic [CC_W-1:0]   clr_cnt_d;
    logic [SC_W-1:0]   scnt;
    logic [SC_W-1:0]   scnt_d;
    logic [WIDTH-1:0]  result_d;
    logic              ovf_d;
    logic              err_d;
    logic              cnt_clr_d;
    logic              cnt_gate_d;
    logic              busy_d;
    logic              res_valid_d;

    logic [WIDTH-1:0]  smp;
    logic              eq_c;
    logic              msb_fall_c;

    cnt_settle_chk #(
        .WIDTH (WIDTH)
    ) u_settle (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .cnt_q      (cnt_q),
        .smp        (smp),
        .eq_c       (eq_c),
        .msb_fall_c (msb_fall_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RC_IDLE;
            timer     <= '0;
            clr_cnt   <= '0;
            scnt      <= '0;
            result    <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            cnt_clr   <= 1'b0;
            cnt_gate  <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_d;
            clr_cnt   <= clr_cnt_d;
            scnt      <= scnt_d;
            result    <= result_d;
            ovf       <= ovf_d;
            err       <= err_d;
            cnt_clr   <= cnt_clr_d;
            cnt_gate  <= cnt_gate_d;
            busy      <= busy_d;
            res_valid <= res_valid_d;
        end
    end

    // Next state and next register values; outputs decode the next state so
    // they line up with the state they describe.
    always_comb begin
        state_nx  = state;
        timer_d   = timer;
        clr_cnt_d = clr_cnt;
        scnt_d    = scnt;
        result_d  = result;
        ovf_d     = ovf;
        err_d     = err;

        case (state)
            RC_IDLE: begin
                if (start) begin
                    state_nx  = RC_CLEAR;
                    timer_d   = (win_len == '0) ? WIN_W'(1) : win_len;
                    clr_cnt_d = '0;
                end
            end

            RC_CLEAR: begin
                ovf_d = 1'b0;
                if (clr_cnt == CC_W'(CLR_CYC - 1)) begin
                    state_nx = RC_COUNT;
                end else begin
                    clr_cnt_d = clr_cnt + CC_W'(1);
                end
            end

            RC_COUNT: begin
                timer_d = timer - WIN_W'(1);
                if (msb_fall_c) begin
                    ovf_d = 1'b1;
                end
                if (stop || (timer == WIN_W'(1))) begin
                    state_nx = RC_SETTLE;
                    scnt_d   = '0;
                end
            end

            RC_SETTLE: begin
                scnt_d = scnt + SC_W'(1);
                if (msb_fall_c) begin
                    ovf_d = 1'b1;
                end
                if ((scnt >= SC_W'(FIRST_CMP)) && eq_c) begin
                    state_nx = RC_DONE;
                    result_d = smp;
                    err_d    = 1'b0;
                end else if (scnt == SC_W'(LAST_SMP)) begin
                    state_nx = RC_DONE;
                    result_d = smp;
                    err_d    = 1'b1;
                end
            end

            RC_DONE: begin
                if (res_valid && res_ready) begin
                    state_nx = RC_IDLE;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end

            default: begin
                state_nx = RC_IDLE;
            end
        endcase

        cnt_clr_d   = (state_nx == RC_CLEAR);
        cnt_gate_d  = (state_nx == RC_COUNT);
        busy_d      = (state_nx != RC_IDLE);
        res_valid_d = (state_nx == RC_DONE);
    end

endmodule

// File: tb/tb_ripple_cnt_ctrl.sv
// Directed bench for ripple_cnt_ctrl with a behavioural ripple counter model.
module tb_ripple_cnt_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] win_len;
    logic [3:0] cnt;
    logic       cnt_clr;
    logic       cnt_gate;
    logic       busy;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] result;
    logic       ovf;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Event source: 0 none, 1 every gate cycle, 2 every second gate cycle.
    int ev_mode  = 0;
    bit tog_mode = 1'b0;
    int gcyc     = 0;

    ripple_cnt_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .win_len   (win_len),
        .cnt_q     (cnt),
        .cnt_clr   (cnt_clr),
        .cnt_gate  (cnt_gate),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .ovf       (ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ripple counter model: events land mid-cycle, away from the sampling edge.
    always @(negedge clk) begin
        if (cnt_clr) begin
            cnt  = 4'd0;
            gcyc = 0;
        end else if (cnt_gate) begin
            gcyc = gcyc + 1;
            if (ev_mode == 1 || (ev_mode == 2 && (gcyc % 2) == 0))
                cnt = cnt + 4'd1;
        end else if (tog_mode && busy) begin
            cnt = cnt ^ 4'd1;
        end
    end

    task automatic release_res();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    // Starts a window and records clear/gate lengths and gate-fall-to-valid latency.
    task automatic run_meas(input logic [7:0] wl, input int mode, input bit tog,
                            output int clr_n, output int gate_n, output int gate_first,
                            output int lat, output bit tmo);
        int  fall_idx;
        bit  seen;
        clr_n = 0; gate_n = 0; gate_first = 0; lat = 0; tmo = 1'b1;
        fall_idx = 0; seen = 1'b0;
        win_len  = wl;
        ev_mode  = mode;
        tog_mode = tog;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            if (cnt_clr) clr_n++;
            if (cnt_gate) begin
                gate_n++;
                if (gate_first == 0) gate_first = i;
                seen = 1'b1;
            end else if (seen && fall_idx == 0) begin
                fall_idx = i;
            end
            if (res_valid) begin
                lat = i - fall_idx;
                tmo = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        tog_mode = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (cnt_clr !== 1'b0)   begin n_fail++; $display("FAIL reset_clr: got %b expected 0", cnt_clr); end
        n_checks++; if (cnt_gate !== 1'b0)  begin n_fail++; $display("FAIL reset_gate: got %b expected 0", cnt_gate); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
        n_checks++; if ({result, ovf, err} !== 6'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", {result, ovf, err}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        int c, g, gf, l; bit t;
        run_meas(8'd20, 2, 1'b0, c, g, gf, l, t);
        n_checks++; if (t !== 1'b0)     begin n_fail++; $display("FAIL nom_timeout: got %b expected 0", t); end
        n_checks++; if (c !== 2)        begin n_fail++; $display("FAIL nom_clr_cycles: got %0d expected 2", c); end
        n_checks++; if (gf !== 3)       begin n_fail++; $display("FAIL nom_gate_start: got %0d expected 3", gf); end
        n_checks++; if (g !== 20)       begin n_fail++; $display("FAIL nom_gate_cycles: got %0d expected 20", g); end
        n_checks++; if (l !== 4)        begin n_fail++; $display("FAIL nom_latency: got %0d expected 4", l); end
        n_checks++; if (result !== 4'd10) begin n_fail++; $display("FAIL nom_result: got %0d expected 10", result); end
        n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL nom_ovf: got %b expected 0", ovf); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL nom_err: got %b expected 0", err); end
        release_res();
        n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL nom_release: got busy=%b valid=%b expected 0 0", busy, res_valid); end
        n_checks++; if (result !== 4'd0) begin n_fail++; $display("FAIL nom_idle_result: got %0d expected 0", result); end
    endtask

    task automatic test_wrap();
        int c, g, gf, l; bit t;
        run_meas(8'd18, 1, 1'b0, c, g, gf, l, t);
        n_checks++; if (t !== 1'b0)      begin n_fail++; $display("FAIL wrap_timeout: got %b expected 0", t); end
        n_checks++; if (g !== 18)        begin n_fail++; $display("FAIL wrap_gate_cycles: got %0d expected 18", g); end
        n_checks++; if (result !== 4'd2) begin n_fail++; $display("FAIL wrap_result: got %0d expected 2", result); end
        n_checks++; if (ovf !== 1'b1)    begin n_fail++; $display("FAIL wrap_ovf: got %b expected 1", ovf); end
        n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL wrap_err: got %b expected 0", err); end
        release_res();
    endtask

    task automatic test_unsettled();
        int c, g, gf, l; bit t;
        // Three events, then the LSB toggles each cycle: last sample is 3 ^ 0.
        run_meas(8'd3, 1, 1'b1, c, g, gf, l, t);
        n_checks++; if (t !== 1'b0)      begin n_fail++; $display("FAIL unset_timeout: got %b expected 0", t); end
        n_checks++; if (l !== 10)        begin n_fail++; $display("FAIL unset_latency: got %0d expected 10", l); end
        n_checks++; if (err !== 1'b1)    begin n_fail++; $display("FAIL unset_err: got %b expected 1", err); end
        n_checks++; if (result !== 4'd3) begin n_fail++; $display("FAIL unset_result: got %0d expected 3", result); end
        n_checks++; if (ovf !== 1'b0)    begin n_fail++; $display("FAIL unset_ovf: got %b expected 0", ovf); end
        release_res();
    endtask

    task automatic test_early_stop();
        int gate_n; bit got;
        gate_n = 0; got = 1'b0;
        win_len = 8'd50; ev_mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !cnt_gate; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 1; i <= 5; i++) begin
            if (cnt_gate) gate_n++;
            if (i == 5) stop = 1'b1;
            @(posedge clk); #1;
        end
        stop = 1'b0;
        n_checks++; if (gate_n !== 5)      begin n_fail++; $display("FAIL stop_gate_cycles: got %0d expected 5", gate_n); end
        n_checks++; if (cnt_gate !== 1'b0) begin n_fail++; $display("FAIL stop_gate_low: got %b expected 0", cnt_gate); end
        n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL stop_busy: got %b expected 1", busy); end
        for (int i = 0; i < 30; i++) begin
            if (res_valid) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (got !== 1'b1)      begin n_fail++; $display("FAIL stop_valid: got %b expected 1", got); end
        n_checks++; if (result !== 4'd5)   begin n_fail++; $display("FAIL stop_result: got %0d expected 5", result); end
        n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL stop_err: got %b expected 0", err); end
        release_res();
    endtask

    task automatic test_backpressure();
        int c, g, gf, l; bit t;
        run_meas(8'd4, 1, 1'b0, c, g, gf, l, t);
        n_checks++; if (t !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", t); end
        for (int i = 0; i < 5; i++) begin
            start = (i == 1);
            n_checks++; if (res_valid !== 1'b1 || result !== 4'd4) begin n_fail++; $display("FAIL bp_hold: got valid=%b result=%0d expected 1 4", res_valid, result); end
            @(posedge clk); #1;
        end
        start = 1'b0;
        release_res();
        n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got busy=%b valid=%b expected 0 0", busy, res_valid); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || cnt_clr !== 1'b0) begin n_fail++; $display("FAIL bp_stray_start: got busy=%b clr=%b expected 0 0", busy, cnt_clr); end
    endtask

    task automatic test_back_to_back();
        int c, g, gf, l; bit t;
        run_meas(8'd2, 1, 1'b0, c, g, gf, l, t);
        n_checks++; if (result !== 4'd2) begin n_fail++; $display("FAIL b2b_result: got %0d expected 2", result); end
        release_res();
        win_len = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (cnt_clr !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got clr=%b busy=%b expected 1 1", cnt_clr, busy); end
        for (int i = 0; i < 40 && !res_valid; i++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (result !== 4'd7) begin n_fail++; $display("FAIL b2b_result2: got %0d expected 7", result); end
        release_res();
    endtask

    task automatic test_reset_mid();
        int c, g, gf, l; bit t;
        win_len = 8'd10; ev_mode = 1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (cnt_gate !== 1'b1) begin n_fail++; $display("FAIL rmid_in_count: got %b expected 1", cnt_gate); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || cnt_gate !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs: got busy=%b gate=%b valid=%b expected 0 0 0", busy, cnt_gate, res_valid); end
        run_meas(8'd0, 1, 1'b0, c, g, gf, l, t);
        n_checks++; if (t !== 1'b0)      begin n_fail++; $display("FAIL rmid_timeout: got %b expected 0", t); end
        n_checks++; if (g !== 1)         begin n_fail++; $display("FAIL rmid_zero_win: got %0d expected 1", g); end
        n_checks++; if (result !== 4'd1) begin n_fail++; $display("FAIL rmid_result: got %0d expected 1", result); end
        release_res();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; win_len = 8'd0;
        res_ready = 1'b0; cnt = 4'd0;
        test_reset();
        test_nominal();
        test_wrap();
        test_unsettled();
        test_early_stop();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ripple_cnt_ctrl.md
# ripple_cnt_ctrl

Measurement-window controller for the team's 4-bit ripple (asynchronous) event counter built from T flip-flops. It clears the counter, gates its input clock for a programmable number of `clk` cycles, waits for the ripple chain to settle, and captures a stable count. The count is returned through a valid/ready handshake. It sits between the ripple counter and any synchronous consumer, and is the only block allowed to drive the counter's clear and gate.

## Interface
Parameters:
- `WIDTH`, default 4: ripple counter width in bits.
- `WIN_W`, default 8: width of the window-length input.
- `CLR_CYC`, default 2: number of cycles `cnt_clr` is held high.
- `SETTLE_MAX`, default 8: maximum number of settle-sampling cycles before an error is flagged.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous active-high reset.
- `start`  in  1: begin a measurement; sampled only in IDLE.
- `stop`  in  1: abort the COUNT phase early; ignored in other states.
- `win_len`  in  WIN_W: window length in cycles; captured on an accepted `start`.
- `cnt_q`  in  WIDTH: ripple counter output; asynchronous to `clk`.
- `cnt_clr`  out  1: clear to the ripple counter.
- `cnt_gate`  out  1: enable for the counter's event clock.
- `busy`  out  1: high in every state except IDLE.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.
- `result`  out  WIDTH: captured count.
- `ovf`  out  1: the counter wrapped during the window.
- `err`  out  1: the count did not settle within SETTLE_MAX cycles.

## Operation
- States: IDLE, CLEAR, COUNT, SETTLE, DONE.
- IDLE:
  - All outputs are 0.
  - `start`=1 captures `win_len` (a value of 0 is treated as 1) and moves to CLEAR.
- CLEAR:
  - `cnt_clr`=1 for exactly CLR_CYC cycles.
  - Clears the `ovf` tracking state, then moves to COUNT.
- COUNT:
  - `cnt_gate`=1 and the window timer decrements every cycle.
  - Exits to SETTLE when the timer expires or on `stop`=1. `cnt_gate` drops in the cycle after `stop` is sampled.
- Overflow tracking:
  - `cnt_q[WIDTH-1]` passes through a 2-flop synchronizer.
  - A synchronized 1→0 transition seen during COUNT or SETTLE sets sticky `ovf`.
- SETTLE:
  - `cnt_gate`=0.
  - `cnt_q` passes through a 2-flop synchronizer and the synchronized value is compared with the previous cycle's value.
  - Two consecutive equal samples load `result` and move to DONE with `err`=0.
  - If no match occurs after SETTLE_MAX samples, `result` takes the last sample, `err`=1, and the FSM moves to DONE.
- DONE:
  - `res_valid`=1.
  - `result`, `ovf` and `err` are held stable until `res_valid && res_ready`, then the FSM returns to IDLE.
- Modulo rule: `result` is the event count mod 2^WIDTH. Counts of 2^WIDTH or more set `ovf`.
- `start` outside IDLE is ignored; it is not queued.
- `stop` and timer expiry in the same cycle: single transition to SETTLE.
- `rst` in any state: next state IDLE and all outputs 0 in the following cycle. `cnt_gate` drops immediately, so a partial count is discarded.

## Timing
- `start` accepted at edge k:
  - `cnt_clr` is high during cycles k+1 … k+CLR_CYC.
  - `cnt_gate` is high for exactly max(`win_len`,1) cycles starting at k+CLR_CYC+1.
- Earliest `res_valid` is 4 cycles after `cnt_gate` falls: 2 cycles of synchronizer delay plus 2 cycles for the equal-sample pair.
- Earliest handshake: `res_valid` and `res_ready` high in the same cycle → IDLE on the next edge. A new `start` is accepted one cycle after that.
- Every output is registered, with no combinational path from input to output.

## Structure
- Package `ripple_ctrl_pkg` holds:
  - the state enum `rc_state_t`;
  - default constants `RC_WIDTH`=4, `RC_CLR_CYC`=2, `RC_SETTLE_MAX`=8.
- Sub-module `cnt_settle_chk`:
  - contains the 2-flop synchronizer for WIDTH bits, the previous-sample register, the equality flag and the MSB falling-edge detect;
  - instantiated once.
- The FSM, window timer and result registers live in the top level.

## Test plan
- Nominal count: `win_len`=20 with 10 events during the gate → `result`=10, `ovf`=0, `err`=0; `cnt_gate` is high for exactly 20 cycles.
- Wrap-around: 18 events with WIDTH=4 → `result`=2, `ovf`=1.
- Unsettled input: `cnt_q` toggles every cycle in SETTLE → `res_valid` arrives after 8 samples with `err`=1.
- Early stop: `win_len`=50 and `stop` at gate cycle 5 → `cnt_gate` is low from cycle 6; `result` equals the events seen in 5 cycles.
- Backpressure and stray start: `res_ready` low for 5 cycles in DONE, plus a `start` pulse during that time → `result` is held constant, the `start` is ignored, and the FSM returns to IDLE one cycle after `res_ready` goes high.
- Reset mid-operation: `rst` during COUNT → next cycle `busy`=0, `cnt_gate`=0, `res_valid`=0; a following `start` with `win_len`=0 gives exactly 1 gate cycle.
